// File: rtl/twobit_seq_decoder.sv
// Decodes a stream of two-bit-set words into {hi,lo} bit indices, queued in an output FIFO.
// Define TWOBIT_ORDER_CHECK_EN to flag words that break the ascending sweep order.
module twobit_seq_decoder #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  localparam int IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  in_word,
  input  logic          in_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_hi,
  output logic [IW-1:0] out_lo,
  output logic [7:0]    err_count,
  output logic [7:0]    drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  function automatic logic [5:0] popcnt(input logic [N-1:0] w);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) r = r + 6'd1;
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] hi_idx(input logic [N-1:0] w);
    logic [IW-1:0] r;
    r = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (w[i]) r = IW'(i);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] lo_idx(input logic [N-1:0] w);
    logic [IW-1:0] r;
    r = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (w[i]) r = IW'(i);
    end
    return r;
  endfunction

  state_t              state_r;
  logic [N-1:0]        prev_word_r;
  logic [2*IW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]       rd_ptr_r;
  logic [AW-1:0]       wr_ptr_r;
  logic [CW-1:0]       count_r;

  logic                word_zero_s;
  logic                two_bits_s;
  logic                dup_s;
  logic                accept_s;
  logic                malformed_s;
  logic                order_err_s;
  logic                pop_s;
  logic                push_ok_s;
  logic                drop_s;
  logic [CW-1:0]       count_n_s;
  logic [AW-1:0]       rd_ptr_n_s;
  logic [AW-1:0]       wr_ptr_n_s;
  logic [2*IW-1:0]     entry_s;
  logic [2*IW-1:0]     head_n_s;

  // Word classification and FIFO push/pop decisions
  always_comb begin
    word_zero_s = (in_word == {N{1'b0}});
    two_bits_s  = (popcnt(in_word) == 6'd2);
    dup_s       = (state_r == TRACK) && (in_word == prev_word_r);
    accept_s    = in_valid && two_bits_s && !dup_s;
    malformed_s = in_valid && !word_zero_s && !two_bits_s;
`ifdef TWOBIT_ORDER_CHECK_EN
    // Ascending sweep, except the wrap from the top pair back to bits 1:0
    order_err_s = accept_s && (state_r == TRACK) &&
                  !((in_word > prev_word_r) ||
                    ((in_word == N'(3)) && prev_word_r[N-1] && prev_word_r[N-2]));
`else
    order_err_s = 1'b0;
`endif
    pop_s       = out_valid && out_ready;
    push_ok_s   = accept_s && ((count_r != CW'(DEPTH)) || pop_s);
    drop_s      = accept_s && !push_ok_s;
    entry_s     = {hi_idx(in_word), lo_idx(in_word)};
  end

  // Next FIFO pointers, occupancy and head entry
  always_comb begin
    count_n_s  = count_r;
    rd_ptr_n_s = rd_ptr_r;
    wr_ptr_n_s = wr_ptr_r;
    head_n_s   = {out_hi, out_lo};
    if (push_ok_s && !pop_s) begin
      count_n_s = count_r + CW'(1);
    end else if (!push_ok_s && pop_s) begin
      count_n_s = count_r - CW'(1);
    end else begin
      count_n_s = count_r;
    end
    if (pop_s) begin
      rd_ptr_n_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_n_s = rd_ptr_r;
    end
    if (push_ok_s) begin
      wr_ptr_n_s = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_n_s = wr_ptr_r;
    end
    // The slot being written this cycle becomes the head: bypass the memory
    if (count_n_s == CW'(0)) begin
      head_n_s = {out_hi, out_lo};
    end else if (push_ok_s && (rd_ptr_n_s == wr_ptr_r)) begin
      head_n_s = entry_s;
    end else begin
      head_n_s = mem_r[rd_ptr_n_s];
    end
  end

  // FSM: state, last accepted word and saturating event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      prev_word_r <= {N{1'b0}};
      err_count   <= 8'd0;
      drop_count  <= 8'd0;
    end else begin
      if (in_valid && word_zero_s) begin
        state_r <= IDLE;
      end else if (accept_s) begin
        state_r     <= TRACK;
        prev_word_r <= in_word;
      end else begin
        state_r <= state_r;
      end
      if ((malformed_s || order_err_s) && (err_count != 8'd255)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
      if (drop_s && (drop_count != 8'd255)) begin
        drop_count <= drop_count + 8'd1;
      end else begin
        drop_count <= drop_count;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and registered head outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r  <= {AW{1'b0}};
      wr_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      out_valid <= 1'b0;
      out_hi    <= {IW{1'b0}};
      out_lo    <= {IW{1'b0}};
    end else begin
      rd_ptr_r  <= rd_ptr_n_s;
      wr_ptr_r  <= wr_ptr_n_s;
      count_r   <= count_n_s;
      out_valid <= (count_n_s != CW'(0));
      {out_hi, out_lo} <= head_n_s;
    end
  end

endmodule

// File: tb/tb_twobit_seq_decoder.sv
// Self-checking bench for twobit_seq_decoder (N=4, DEPTH=4): vector table,
// hand-written FIFO/reset sequences and randomized traffic against a queue model.
module tb_twobit_seq_decoder;

  localparam int N     = 4;
  localparam int DEPTH = 4;
`ifdef TWOBIT_ORDER_CHECK_EN
  localparam int ORD_ERR = 1;
`else
  localparam int ORD_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] in_word;
  logic       in_valid;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_hi;
  logic [1:0] out_lo;
  logic [7:0] err_count;
  logic [7:0] drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: expected FIFO contents as hi*16+lo values
  int q[$];
  bit have_prev;
  int prev;
  int m_err;
  int m_drop;

  twobit_seq_decoder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_word(in_word), .in_valid(in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
    .err_count(err_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] w;
    logic       rdy;
    logic       ev;
    int         ehi;
    int         elo;
    int         eerr;
    int         edrop;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic v, logic [3:0] w, logic rdy, logic ev, int ehi, int elo, int eerr, int edrop);
    vec_t r;
    r.v = v; r.w = w; r.rdy = rdy; r.ev = ev;
    r.ehi = ehi; r.elo = elo; r.eerr = eerr; r.edrop = edrop;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hilo(int w);
    int hi = -1;
    int lo = -1;
    for (int b = 0; b < N; b++) begin
      if ((w >> b) & 1) begin
        if (lo < 0) lo = b;
        hi = b;
      end
    end
    return hi * 16 + lo;
  endfunction

  task automatic model_reset();
    q.delete();
    have_prev = 1'b0;
    prev = 0;
    m_err = 0;
    m_drop = 0;
  endtask

  // One rising edge of the reference behaviour
  task automatic model_edge(input logic v, input int w, input logic rdy);
    bit pop;
    pop = (q.size() > 0) && rdy;
    if (pop) void'(q.pop_front());
    if (v) begin
      if (w == 0) begin
        have_prev = 1'b0;
      end else if ($countones(w) != 2) begin
        if (m_err < 255) m_err++;
      end else if (!(have_prev && w == prev)) begin
`ifdef TWOBIT_ORDER_CHECK_EN
        if (have_prev && !(w > prev || (w == 3 && ((prev >> (N - 2)) & 3) == 3)))
          if (m_err < 255) m_err++;
`endif
        prev = w;
        have_prev = 1'b1;
        if (q.size() < DEPTH) q.push_back(hilo(w));
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      chk("model_hi", out_hi, q[0] / 16);
      chk("model_lo", out_lo, q[0] % 16);
    end
    chk("model_err", err_count, m_err);
    chk("model_drop", drop_count, m_drop);
  endtask

  task automatic step(input logic v, input logic [3:0] w, input logic rdy);
    @(negedge clk);
    in_valid = v; in_word = w; out_ready = rdy;
    @(posedge clk);
    model_edge(v, int'(w), rdy);
    #1;
    check_model();
  endtask

  task automatic expect_head(input string nm, input logic ev, input int hi, input int lo);
    chk({nm, "_valid"}, out_valid, ev);
    if (ev) begin
      chk({nm, "_hi"}, out_hi, hi);
      chk({nm, "_lo"}, out_lo, lo);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_hi", out_hi, 2'd0);
    chk("rst_lo", out_lo, 2'd0);
    chk("rst_err", err_count, 8'd0);
    chk("rst_drop", drop_count, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_word = 4'd0; out_ready = 1'b0;
    model_reset();

    tbl[0]  = mk(1'b1, 4'd0,  1'b1, 1'b0, 0, 0, 0, 0);
    tbl[1]  = mk(1'b1, 4'd3,  1'b1, 1'b1, 1, 0, 0, 0);
    tbl[2]  = mk(1'b1, 4'd3,  1'b1, 1'b0, 0, 0, 0, 0);
    tbl[3]  = mk(1'b1, 4'd5,  1'b1, 1'b1, 2, 0, 0, 0);
    tbl[4]  = mk(1'b1, 4'd5,  1'b1, 1'b0, 0, 0, 0, 0);
    tbl[5]  = mk(1'b1, 4'd6,  1'b1, 1'b1, 2, 1, 0, 0);
    tbl[6]  = mk(1'b1, 4'd9,  1'b1, 1'b1, 3, 0, 0, 0);
    tbl[7]  = mk(1'b1, 4'd10, 1'b1, 1'b1, 3, 1, 0, 0);
    tbl[8]  = mk(1'b1, 4'd12, 1'b1, 1'b1, 3, 2, 0, 0);
    tbl[9]  = mk(1'b1, 4'd3,  1'b1, 1'b1, 1, 0, 0, 0);
    tbl[10] = mk(1'b1, 4'd7,  1'b1, 1'b0, 0, 0, 1, 0);
    tbl[11] = mk(1'b1, 4'd8,  1'b1, 1'b0, 0, 0, 2, 0);
    tbl[12] = mk(1'b1, 4'd3,  1'b1, 1'b0, 0, 0, 2, 0);
    tbl[13] = mk(1'b1, 4'd6,  1'b1, 1'b1, 2, 1, 2, 0);
    tbl[14] = mk(1'b1, 4'd5,  1'b1, 1'b1, 2, 0, 2 + ORD_ERR, 0);
    tbl[15] = mk(1'b0, 4'd5,  1'b1, 1'b0, 0, 0, 2 + ORD_ERR, 0);

    do_reset();

    // Vector table: sweep decode, duplicates, malformed words, order resync
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].rdy);
      expect_head($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ehi, tbl[i].elo);
      chk($sformatf("tbl%0d_err", i), err_count, tbl[i].eerr);
      chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].edrop);
    end

    // Fill with the consumer stalled; fifth word is dropped, head stays put
    do_reset();
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    expect_head("stall", 1'b1, 1, 0);
    step(1'b1, 4'd10, 1'b0);
    expect_head("full", 1'b1, 1, 0);
    chk("full_drop", drop_count, 8'd1);
    // Push into a full FIFO together with a pop: accepted, no drop
    step(1'b1, 4'd12, 1'b1);
    expect_head("push_pop", 1'b1, 2, 0);
    chk("push_pop_drop", drop_count, 8'd1);
    step(1'b0, 4'd0, 1'b1);
    expect_head("drain1", 1'b1, 2, 1);
    step(1'b0, 4'd0, 1'b1);
    expect_head("drain2", 1'b1, 3, 0);
    step(1'b0, 4'd0, 1'b1);
    expect_head("drain3", 1'b1, 3, 2);
    step(1'b0, 4'd0, 1'b1);
    expect_head("drain4", 1'b0, 0, 0);

    // Reset with entries queued, then a word that would be out of order
    do_reset();
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd12, 1'b0);
    chk("pre_rst_valid", out_valid, 1'b1);
    do_reset();
    step(1'b1, 4'd9, 1'b1);
    expect_head("post_rst", 1'b1, 3, 0);
    chk("post_rst_err", err_count, 8'd0);

    // Randomized traffic; the second phase starves the consumer to force drops
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [3:0] w;
      logic rdy;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        w = 4'd0;
      end else if (sel <= 6) begin
        int a;
        int b;
        a = $urandom_range(0, N - 1);
        b = (a + 1 + $urandom_range(0, N - 2)) % N;
        w = 4'((1 << a) | (1 << b));
      end else begin
        w = 4'($urandom_range(0, 15));
      end
      if (i < 1800) rdy = ($urandom_range(0, 1) == 1);
      else          rdy = ($urandom_range(0, 9) == 0);
      step(($urandom_range(0, 3) != 0), w, rdy);
    end
    chk("sat_err", err_count, 8'd255);
    chk("sat_drop", drop_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
